flag_fifo_buf: RTL and testbench
================================

Name: flag_fifo_buf

Overview:
- Parametrised successor to the single-entry flag buffer: a DEPTH-entry first-word-fall-through FIFO between a byte producer (e.g. UART rx) and a consumer (e.g. ALU/interface FSM).
- Provides empty/full/almost-full status, an occupancy count, and sticky overrun/underrun error flags.
- Full-condition policy is selectable: drop the new word, or overwrite the oldest.

Parameters:
- W, 8, data width in bits.
- ADDR_W, 2, pointer width; DEPTH = 2**ADDR_W entries.
- AF_THRESH, 3, o_almost_full asserts when count >= AF_THRESH; legal range 1..DEPTH.
- OVERWRITE, 0, 0 = drop new word when full; 1 = discard oldest and store new word when full.

Ports:
- i_clk  input  1  clock, rising edge.
- i_reset  input  1  asynchronous, active-high reset.
- i_wr  input  1  push i_din this cycle (the set_flag analogue).
- i_din  input  W  write data.
- i_rd  input  1  pop head entry this cycle (the clr_flag analogue).
- i_clr_err  input  1  clear o_ovr and o_udr.
- o_dout  output  W  head entry; forced to 0 when o_empty.
- o_empty  output  1  no entries held.
- o_full  output  1  count == DEPTH.
- o_almost_full  output  1  count >= AF_THRESH.
- o_count  output  ADDR_W+1  entries held, 0..DEPTH.
- o_ovr  output  1  sticky: a write occurred while full without a simultaneous read.
- o_udr  output  1  sticky: a read occurred while empty.

Behaviour:
- Reset (async, any time, including mid-operation):
  - rd_ptr = wr_ptr = 0, count = 0, o_empty = 1, o_full = 0, o_almost_full = 0, o_ovr = 0, o_udr = 0, o_dout = 0.
  - Storage array is not reset; its contents are unobservable because o_dout is gated by o_empty.
- All outputs are registered state or a mux of registered state. There is no combinational path from any input to any output.
- FWFT: o_dout = mem[rd_ptr] whenever !o_empty. A word written at edge N is visible on o_dout after edge N if the FIFO was empty.
- Pointers are ADDR_W bits and wrap modulo DEPTH with natural overflow. count is tracked explicitly; full/empty derive from count.
- Per-cycle cases, evaluated at the rising edge:
  - wr only, not full: mem[wr_ptr] = i_din, wr_ptr++, count++.
  - wr only, full, OVERWRITE=0: no state change except o_ovr = 1.
  - wr only, full, OVERWRITE=1: mem[wr_ptr] = i_din, wr_ptr++, rd_ptr++ (oldest lost), count stays DEPTH, o_ovr = 1.
  - rd only, not empty: rd_ptr++, count--.
  - rd only, empty: no state change except o_udr = 1.
  - wr and rd, not empty (including full): write and pop both occur, count unchanged, no error.
  - wr and rd, empty: write accepted (count becomes 1), read ignored, o_udr = 1.
  - neither: hold.
- Error flags are sticky until i_clr_err. If i_clr_err and a new error event occur in the same cycle, set wins (flag = 1), matching the set-over-clear priority of the existing flag buffer.
- i_clr_err has no effect on data, pointers or count.
- Status (o_empty, o_full, o_almost_full, o_count) updates on the same edge as the count change, with one cycle of latency from the i_wr/i_rd sample.

Decomposition:
- No shared package needed; all constants are local parameters (DEPTH) derived from ADDR_W.
- One natural sub-module: fifo_regfile (W x DEPTH register array, synchronous write port, asynchronous read port).
- Pointer/count/flag control stays in flag_fifo_buf.

Test Plan (W=8, ADDR_W=2, AF_THRESH=3):
- Reset, then idle -> o_empty=1, o_count=0, o_dout=0x00, o_ovr=0, o_udr=0.
- Push 0xA1,0xB2,0xC3 on three cycles -> after 1st edge o_dout=0xA1, count=1; after 3rd edge count=3, o_almost_full=1, o_full=0.
- Push 0xD4 (full), then push 0xE5 with OVERWRITE=0 -> count=4, o_full=1, o_ovr=1; pop four times yields 0xA1,0xB2,0xC3,0xD4, then o_empty=1.
- Same sequence with OVERWRITE=1 -> o_ovr=1, count stays 4, pops yield 0xB2,0xC3,0xD4,0xE5.
- Pop while empty, with i_clr_err asserted in the same cycle -> o_udr=1 (set wins); i_clr_err alone next cycle -> o_udr=0.
- Full FIFO, simultaneous wr 0x55 and rd; then 8 push/pop wrap cycles; then assert i_reset mid-stream -> simultaneous op: count stays 4, o_ovr stays 0; wrap cycles: data order preserved across pointer wrap; reset: immediate (asynchronous) return to reset values.

Source files
------------

// File: rtl/flag_fifo_buf_regfile.sv
// W x DEPTH storage for flag_fifo_buf.
// Synchronous write port and asynchronous read port. There is no reset:
// the parent gates the read data with its empty flag.
module fifo_regfile #(
   parameter int W      = 8,
   parameter int ADDR_W = 2
) (
   input  logic              i_clk,
   input  logic              i_we,
   input  logic [ADDR_W-1:0] i_waddr,
   input  logic [W-1:0]      i_wdata,
   input  logic [ADDR_W-1:0] i_raddr,
   output logic [W-1:0]      o_rdata
);
   localparam int DEPTH = 1 << ADDR_W;

   logic [W-1:0] r_mem [DEPTH];

   // write port: store the word at the write address when enabled
   always_ff @(posedge i_clk) begin
      if (i_we) r_mem[i_waddr] <= i_wdata;
   end

   assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/flag_fifo_buf.sv
// DEPTH-entry first-word-fall-through FIFO with status and sticky error flags.
// The occupancy count is held explicitly, and full/empty are decoded from it.
// Every output is decoded or muxed from registered state.
module flag_fifo_buf #(
   parameter int W         = 8,
   parameter int ADDR_W    = 2,
   parameter int AF_THRESH = 3,
   parameter int OVERWRITE = 0
) (
   input  logic            i_clk,
   input  logic            i_reset,
   input  logic            i_wr,
   input  logic [W-1:0]    i_din,
   input  logic            i_rd,
   input  logic            i_clr_err,
   output logic [W-1:0]    o_dout,
   output logic            o_empty,
   output logic            o_full,
   output logic            o_almost_full,
   output logic [ADDR_W:0] o_count,
   output logic            o_ovr,
   output logic            o_udr
);
   localparam int DEPTH = 1 << ADDR_W;
   localparam logic [ADDR_W:0]   CNT_FULL = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0]   CNT_AF   = (ADDR_W+1)'(AF_THRESH);
   localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
   localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

   logic [ADDR_W-1:0] r_wr_ptr, r_rd_ptr;
   logic [ADDR_W:0]   r_count;
   logic              r_ovr, r_udr;

   logic              w_empty, w_full, w_ow;
   logic              w_do_wr, w_do_rd, w_ovr_evt, w_udr_evt;
   logic [W-1:0]      w_rdata;

   assign w_empty = (r_count == '0);
   assign w_full  = (r_count == CNT_FULL);
   assign w_ow    = (OVERWRITE != 0);

   // decode this cycle's accepted write/pop and any error events
   always_comb begin
      w_ovr_evt = 1'b0;
      w_udr_evt = 1'b0;
      w_do_wr   = 1'b0;
      w_do_rd   = 1'b0;
      if (i_wr && i_rd) begin
         // a read on an empty FIFO is ignored, but the write still lands
         w_do_wr   = 1'b1;
         w_do_rd   = !w_empty;
         w_udr_evt = w_empty;
      end else if (i_wr) begin
         // when full, either drop the new word or push out the oldest entry
         w_do_wr   = !w_full || w_ow;
         w_do_rd   = w_full && w_ow;
         w_ovr_evt = w_full;
      end else if (i_rd) begin
         w_do_rd   = !w_empty;
         w_udr_evt = w_empty;
      end
   end

   // pointers and occupancy; a simultaneous write and pop leaves count unchanged
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_wr) r_wr_ptr <= r_wr_ptr + PTR_ONE;
         if (w_do_rd) r_rd_ptr <= r_rd_ptr + PTR_ONE;
         if (w_do_wr && !w_do_rd)      r_count <= r_count + CNT_ONE;
         else if (!w_do_wr && w_do_rd) r_count <= r_count - CNT_ONE;
      end
   end

   // sticky error flags; a new event in the same cycle overrides the clear
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_ovr <= 1'b0;
         r_udr <= 1'b0;
      end else begin
         r_ovr <= (r_ovr && !i_clr_err) || w_ovr_evt;
         r_udr <= (r_udr && !i_clr_err) || w_udr_evt;
      end
   end

   fifo_regfile #(.W(W), .ADDR_W(ADDR_W)) u_regfile (
      .i_clk   (i_clk),
      .i_we    (w_do_wr),
      .i_waddr (r_wr_ptr),
      .i_wdata (i_din),
      .i_raddr (r_rd_ptr),
      .o_rdata (w_rdata)
   );

   assign o_dout        = w_empty ? '0 : w_rdata;
   assign o_empty       = w_empty;
   assign o_full        = w_full;
   assign o_almost_full = (r_count >= CNT_AF);
   assign o_count       = r_count;
   assign o_ovr         = r_ovr;
   assign o_udr         = r_udr;
endmodule

// File: tb/tb_flag_fifo_buf.sv
// Bench for flag_fifo_buf: one instance for each full-condition policy, both
// fed the same stimulus. Each instance is checked against a queue-based model.
module tb_flag_fifo_buf;
   logic       i_clk = 1'b0;
   logic       i_reset, i_wr, i_rd, i_clr_err;
   logic [7:0] i_din;

   logic [7:0] o_dout0, o_dout1;
   logic       o_empty0, o_full0, o_af0, o_ovr0, o_udr0;
   logic       o_empty1, o_full1, o_af1, o_ovr1, o_udr1;
   logic [2:0] o_count0, o_count1;

   int n_chk = 0;
   int n_err = 0;

   // model state: contents of each FIFO and its sticky flags (index = OVERWRITE)
   logic [7:0] mq [2][$];
   bit         m_ovr [2];
   bit         m_udr [2];

   always #5 i_clk = ~i_clk;

   flag_fifo_buf #(.W(8), .ADDR_W(2), .AF_THRESH(3), .OVERWRITE(0)) u_drop (
      .i_clk(i_clk), .i_reset(i_reset), .i_wr(i_wr), .i_din(i_din), .i_rd(i_rd),
      .i_clr_err(i_clr_err), .o_dout(o_dout0), .o_empty(o_empty0), .o_full(o_full0),
      .o_almost_full(o_af0), .o_count(o_count0), .o_ovr(o_ovr0), .o_udr(o_udr0)
   );

   flag_fifo_buf #(.W(8), .ADDR_W(2), .AF_THRESH(3), .OVERWRITE(1)) u_ovwr (
      .i_clk(i_clk), .i_reset(i_reset), .i_wr(i_wr), .i_din(i_din), .i_rd(i_rd),
      .i_clr_err(i_clr_err), .o_dout(o_dout1), .o_empty(o_empty1), .o_full(o_full1),
      .o_almost_full(o_af1), .o_count(o_count1), .o_ovr(o_ovr1), .o_udr(o_udr1)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic model_clear();
      for (int p = 0; p < 2; p++) begin
         mq[p].delete();
         m_ovr[p] = 0;
         m_udr[p] = 0;
      end
   endtask

   task automatic model_step(input bit wr, input bit rd, input bit clr, input logic [7:0] din);
      for (int p = 0; p < 2; p++) begin
         bit e, f, ovr_e, udr_e;
         logic [7:0] junk;
         e = (mq[p].size() == 0);
         f = (mq[p].size() == 4);
         ovr_e = 0;
         udr_e = 0;
         if (wr && rd) begin
            if (e) udr_e = 1;
            else junk = mq[p].pop_front();
            mq[p].push_back(din);
         end else if (wr) begin
            if (!f) mq[p].push_back(din);
            else begin
               ovr_e = 1;
               if (p == 1) begin
                  junk = mq[p].pop_front();
                  mq[p].push_back(din);
               end
            end
         end else if (rd) begin
            if (e) udr_e = 1;
            else junk = mq[p].pop_front();
         end
         if (clr) begin
            m_ovr[p] = 0;
            m_udr[p] = 0;
         end
         if (ovr_e) m_ovr[p] = 1;
         if (udr_e) m_udr[p] = 1;
      end
   endtask

   task automatic check_p(input string tag, input int p, input logic [7:0] dout,
                          input logic emp, input logic full, input logic af,
                          input logic [2:0] cnt, input logic ovr, input logic udr);
      int n;
      logic [7:0] exp_dout;
      n = mq[p].size();
      exp_dout = (n > 0) ? mq[p][0] : 8'h00;
      chk($sformatf("%s/ow%0d/count", tag, p), cnt, n);
      chk($sformatf("%s/ow%0d/empty", tag, p), emp, n == 0);
      chk($sformatf("%s/ow%0d/full", tag, p), full, n == 4);
      chk($sformatf("%s/ow%0d/afull", tag, p), af, n >= 3);
      chk($sformatf("%s/ow%0d/dout", tag, p), dout, exp_dout);
      chk($sformatf("%s/ow%0d/ovr", tag, p), ovr, m_ovr[p]);
      chk($sformatf("%s/ow%0d/udr", tag, p), udr, m_udr[p]);
   endtask

   task automatic check_all(input string tag);
      check_p(tag, 0, o_dout0, o_empty0, o_full0, o_af0, o_count0, o_ovr0, o_udr0);
      check_p(tag, 1, o_dout1, o_empty1, o_full1, o_af1, o_count1, o_ovr1, o_udr1);
   endtask

   // drive one cycle of inputs (called just after a falling edge), then check
   task automatic step(input bit wr, input bit rd, input logic [7:0] din, input bit clr,
                       input string tag);
      i_wr = wr;
      i_rd = rd;
      i_din = din;
      i_clr_err = clr;
      @(posedge i_clk);
      model_step(wr, rd, clr, din);
      @(negedge i_clk);
      i_wr = 0;
      i_rd = 0;
      i_clr_err = 0;
      check_all(tag);
   endtask

   initial begin
      i_reset = 1;
      i_wr = 0;
      i_rd = 0;
      i_clr_err = 0;
      i_din = 8'h00;
      model_clear();
      repeat (2) @(negedge i_clk);
      i_reset = 0;
      check_all("reset");
      step(0, 0, 8'h00, 0, "idle");

      step(1, 0, 8'hA1, 0, "push1");
      step(1, 0, 8'hB2, 0, "push2");
      step(1, 0, 8'hC3, 0, "push3");
      step(1, 0, 8'hD4, 0, "push_full");
      step(1, 0, 8'hE5, 0, "push_when_full");
      for (int i = 0; i < 4; i++) step(0, 1, 8'h00, 0, $sformatf("drain%0d", i));

      step(0, 1, 8'h00, 1, "udr_set_wins");
      step(0, 0, 8'h00, 1, "clr_err");

      for (int i = 0; i < 4; i++) step(1, 0, 8'(i * 16 + 3), 0, $sformatf("fill%0d", i));
      step(1, 1, 8'h55, 0, "simul_full");
      for (int i = 0; i < 8; i++) step(1, 1, 8'($urandom), 0, $sformatf("wrap%0d", i));

      // asynchronous reset asserted mid low phase, sampled before any clock edge
      #2 i_reset = 1;
      #1 model_clear();
      check_all("async_reset");
      @(negedge i_clk);
      i_reset = 0;
      check_all("post_reset");

      for (int i = 0; i < 600; i++) begin
         bit wr, rd, clr;
         wr  = ($urandom_range(0, 99) < 55);
         rd  = ($urandom_range(0, 99) < 45);
         clr = ($urandom_range(0, 7) == 0);
         step(wr, rd, 8'($urandom), clr, $sformatf("rand%0d", i));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
